fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8x8 sync FIFO.
//  Configurable width/depth, programmable almost thresholds, optional first-word-fall-through.
//  Adds sticky overflow/underflow error flags, a synchronous flush and an occupancy count.
//  Sits between producer/consumer stages in the same clock domain.
// PARAMETERS
//  DATA_W  8         data word width, >=1
//  DEPTH   16        entries; power of 2, >=4; AW = log2(DEPTH)
//  AF_LVL  DEPTH-2   almost_full asserted when count >= AF_LVL (1..DEPTH)
//  AE_LVL  2         almost_empty asserted when count <= AE_LVL (0..DEPTH-1)
//  FWFT    0         0 = standard registered read; 1 = first-word-fall-through
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous reset, active-low (asserted when 0)
//  flush         in   1        synchronous clear of contents and pointers
//  wr_en         in   1        write request
//  d_in          in   DATA_W   write data
//  rd_en         in   1        read request (pop)
//  d_out         out  DATA_W   read data
//  rd_valid      out  1        d_out holds valid data
//  count         out  AW+1     occupancy, 0..DEPTH
//  full          out  1        count == DEPTH
//  empty         out  1        count == 0
//  half_full     out  1        count >= DEPTH/2
//  almost_full   out  1        count >= AF_LVL
//  almost_empty  out  1        count <= AE_LVL
//  overflow      out  1        sticky: write rejected
//  underflow     out  1        sticky: read rejected
//  clr_err       in   1        synchronous clear of overflow/underflow
// BEHAVIOUR
//  Reset (rst=0, async):
//   - ptrs = 0, count = 0, d_out = 0, rd_valid = 0, overflow = underflow = 0.
//   - empty = almost_empty = 1; full = half_full = almost_full = 0.
//   - Memory contents are not reset. Mid-operation reset discards all data immediately.
//  Acceptance, per cycle:
//   - rd_acc = rd_en & !empty.
//   - wr_acc = wr_en & (!full | rd_acc); a write while full is accepted only with a same-cycle pop.
//   - A read while empty is always rejected, even with a same-cycle write.
//  Pointers:
//   - AW-bit wr_ptr/rd_ptr, increment on accept, natural wrap DEPTH-1 -> 0.
//   - count += wr_acc - rd_acc; simultaneous accepted read+write leaves count unchanged.
//  Flags:
//   - Registered, derived from next-state count; valid the same cycle as count.
//  FWFT=0:
//   - On rd_acc, d_out <= mem[rd_ptr] and rd_valid <= 1 at the next edge (1-cycle latency).
//   - Otherwise rd_valid <= 0 and d_out holds its value.
//  FWFT=1:
//   - d_out = mem[rd_ptr] whenever !empty; rd_valid = !empty.
//   - rd_en consumes the presented word; the next word appears the cycle after the pop.
//   - Write-to-d_out latency into an empty FIFO is 1 cycle (the word is visible after the write edge).
//  Errors:
//   - overflow <= 1 on wr_en & !wr_acc; underflow <= 1 on rd_en & !rd_acc.
//   - clr_err clears both flags; a new error in the same cycle as clr_err wins (flag stays 1).
//  flush:
//   - Priority over wr_en/rd_en. Next edge: ptrs = 0, count = 0, flags as at reset, rd_valid = 0.
//   - Does not clear overflow/underflow. Requests during a flush cycle are ignored, with no error set.
// TESTING (DATA_W=8, DEPTH=16, AF_LVL=14, AE_LVL=2)
//  1. Write 16 words 0x01..0x10, then a 17th (0xFF).
//     -> full=1, count=16, overflow=1, 0xFF dropped.
//     -> Read 16 returns 0x01..0x10 with 1-cycle rd_valid latency.
//  2. Threshold sweep: write one word per cycle.
//     -> almost_empty deasserts at count=3; half_full asserts at 8; almost_full at 14; full at 16.
//  3. At full, wr_en=rd_en=1 for 4 cycles with 0xA0..0xA3.
//     -> count stays 16, no overflow, 0xA0..0xA3 read last.
//     -> Also exercises pointer wrap.
//  4. Empty FIFO, rd_en=1 with wr_en=1 (0x55).
//     -> underflow=1, count=1, rd_valid=0.
//     -> clr_err next cycle clears underflow.
//  5. FWFT=1: write 0x3C into empty FIFO.
//     -> d_out=0x3C, rd_valid=1 the next cycle, with no rd_en.
//     -> Pop -> empty=1, rd_valid=0.
//  6. Write 5 words; assert flush, then rst=0 mid-burst.
//     -> count=0, empty=1, overflow unchanged by flush.
//     -> Async reset clears all outputs before the next clk edge.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle between a producer/consumer stage and the parametrised sync FIFO.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] d_in;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] d_out;
  logic              rd_valid;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              half_full;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, d_in, rd_en, clr_err,
    input  d_out, rd_valid, count, full, empty, half_full,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, d_in, rd_en, clr_err,
    output d_out, rd_valid, count, full, empty, half_full,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost thresholds, optional FWFT,
// sticky overflow/underflow flags, synchronous flush and occupancy count.
module fifo_sync_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count_q, count_nxt;
  logic              full_q, empty_q, half_q, af_q, ae_q;
  logic              ovf_q, unf_q;
  logic              rd_acc, wr_acc, wr_err, rd_err;

  // A pop frees a slot in the same cycle, so a write while full needs rd_acc.
  always_comb begin
    rd_acc = bus.rd_en & ~empty_q & ~bus.flush;
    wr_acc = bus.wr_en & (~full_q | rd_acc) & ~bus.flush;
    wr_err = bus.wr_en & ~wr_acc & ~bus.flush;
    rd_err = bus.rd_en & ~rd_acc & ~bus.flush;
    if (bus.flush)
      count_nxt = '0;
    else
      count_nxt = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= bus.d_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      half_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == FULL_CNT);
      empty_q <= (count_nxt == '0);
      half_q  <= (count_nxt >= HALF_CNT);
      af_q    <= (count_nxt >= AF_CNT);
      ae_q    <= (count_nxt <= AE_CNT);
      // A fresh error outranks clr_err in the same cycle.
      ovf_q   <= (ovf_q & ~bus.clr_err) | wr_err;
      unf_q   <= (unf_q & ~bus.clr_err) | rd_err;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.d_out    = empty_q ? '0 : mem[rd_ptr];
      assign bus.rd_valid = ~empty_q;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              rv_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
          rv_q   <= 1'b1;
        end else begin
          rv_q   <= 1'b0;
        end
      end

      assign bus.d_out    = dout_q;
      assign bus.rd_valid = rv_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.half_full    = half_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-read and an FWFT instance share stimulus
// and are checked every cycle against a queue model, plus literal expectations.
module tb_fifo_sync_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] d_in = 8'h00;

  int n_chk  = 0;
  int n_pass = 0;

  fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) bus0 ();
  fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) bus1 ();

  assign bus0.flush = flush;  assign bus1.flush = flush;
  assign bus0.wr_en = wr_en;  assign bus1.wr_en = wr_en;
  assign bus0.rd_en = rd_en;  assign bus1.rd_en = rd_en;
  assign bus0.d_in  = d_in;   assign bus1.d_in  = d_in;
  assign bus0.clr_err = clr_err; assign bus1.clr_err = clr_err;

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: occupancy is just the queue size.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0, m_rv0 = 1'b0;
  logic [7:0] m_d0 = 8'h00;

  function automatic logic [6:0] exp_flags();
    int sz = q.size();
    return {sz == 16, sz == 0, sz >= 8, sz >= 14, sz <= 2, m_ovf, m_unf};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rv0 = 1'b0; m_d0 = 8'h00;
    end else begin
      if (flush) begin
        q.delete();
        m_rv0 = 1'b0;
        if (clr_err) begin m_ovf = 1'b0; m_unf = 1'b0; end
      end else begin
        bit racc, wacc;
        racc = rd_en && q.size() != 0;
        wacc = wr_en && (q.size() != 16 || racc);
        if (racc) begin m_d0 = q.pop_front(); m_rv0 = 1'b1; end
        else m_rv0 = 1'b0;
        if (wacc) q.push_back(d_in);
        m_ovf = (m_ovf && !clr_err) || (wr_en && !wacc);
        m_unf = (m_unf && !clr_err) || (rd_en && !racc);
      end
      #1;
      chk("count0", 32'(bus0.count), 32'(q.size()));
      chk("count1", 32'(bus1.count), 32'(q.size()));
      chk("flags0", {bus0.full, bus0.empty, bus0.half_full, bus0.almost_full,
                     bus0.almost_empty, bus0.overflow, bus0.underflow}, 32'(exp_flags()));
      chk("flags1", {bus1.full, bus1.empty, bus1.half_full, bus1.almost_full,
                     bus1.almost_empty, bus1.overflow, bus1.underflow}, 32'(exp_flags()));
      chk("std_out", {bus0.rd_valid, bus0.d_out}, {m_rv0, m_d0});
      chk("fwft_out", {bus1.rd_valid, bus1.d_out},
          (q.size() != 0) ? {1'b1, q[0]} : 9'h000);
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; d_in = d; rd_en = r;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(bus0.count), 0);
    chk("rst_flags", {bus0.full, bus0.empty, bus0.half_full, bus0.almost_full,
                      bus0.almost_empty, bus0.overflow, bus0.underflow}, 7'b0100100);
    chk("rst_out", {bus0.rd_valid, bus0.d_out}, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: fill, overflow, drain in order
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("t1_full", {bus0.full, bus0.overflow}, 2'b10);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("t1_count", 32'(bus0.count), 16);
    chk("t1_ovf", bus0.overflow, 1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("t1_clr", bus0.overflow, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("t1_rd", {bus0.rd_valid, bus0.d_out}, {1'b1, 8'(i)});
    end
    @(negedge clk);
    chk("t1_end", {bus0.rd_valid, bus0.empty}, 2'b01);

    // 2: threshold sweep
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 8'(k), 1'b0);
      chk("t2_count", 32'(bus0.count), 32'(k));
      chk("t2_flags", {bus0.almost_empty, bus0.half_full, bus0.almost_full, bus0.full},
          {k <= 2, k >= 8, k >= 14, k == 16});
    end

    // 3: simultaneous push/pop at full, then drain across the wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b1);
    chk("t3_count", 32'(bus0.count), 16);
    chk("t3_ovf", bus0.overflow, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("t3_rd", bus0.d_out, (i < 12) ? 8'(5 + i) : 8'hA0 + 8'(i - 12));
    end
    @(negedge clk);

    // 4: read on empty with same-cycle write
    cyc(1'b1, 8'h55, 1'b1);
    chk("t4_unf", {bus0.underflow, bus0.rd_valid}, 2'b10);
    chk("t4_count", 32'(bus0.count), 1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("t4_clr", bus0.underflow, 0);
    chk("t4_fwft", {bus1.rd_valid, bus1.d_out}, 9'h155);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t4_pop", {bus1.empty, bus1.rd_valid, bus0.rd_valid, bus0.d_out}, {3'b101, 8'h55});

    // 5: FWFT fall-through with no rd_en
    cyc(1'b1, 8'h3C, 1'b0);
    chk("t5_fall", {bus1.rd_valid, bus1.d_out}, 9'h13C);
    @(negedge clk);
    chk("t5_hold", {bus1.rd_valid, bus1.d_out}, 9'h13C);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t5_pop", {bus1.empty, bus1.rd_valid}, 2'b10);

    // 6: flush keeps sticky errors, async reset clears immediately
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    chk("t6_pre", {bus0.underflow, 32'(bus0.count)}, {1'b1, 32'd5});
    flush = 1'b1; cyc(1'b1, 8'h77, 1'b1); flush = 1'b0;
    chk("t6_flush", {bus0.count, bus0.empty, bus0.almost_empty, bus0.underflow, bus0.overflow},
        {5'd0, 4'b1110});
    cyc(1'b1, 8'h21, 1'b0);
    cyc(1'b1, 8'h22, 1'b1);
    chk("t6_pre_rst", {bus0.rd_valid, bus0.d_out, 32'(bus0.count)}, {9'h121, 32'd1});
    #2 rst = 1'b0;
    #1;
    chk("t6_rst", {bus0.count, bus0.empty, bus0.almost_empty, bus0.underflow,
                   bus0.rd_valid, bus0.d_out, bus1.rd_valid}, {5'd0, 3'b110, 9'h000, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
